// File: rtl/one_counter_pkg.sv
// Shared state encodings and mode constants for the iterative one-counter family.
package one_counter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MODE_ONES  = 1'b0;
  localparam logic MODE_ZEROS = 1'b1;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

endpackage

// File: rtl/popcount_chunk.sv
// Combinational population count of a W-bit slice.
module popcount_chunk #(
  parameter int unsigned W = 4,
  localparam int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_bits,
  output logic [CW-1:0] o_cnt
);

  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < int'(W); i++) begin
      o_cnt = o_cnt + CW'(i_bits[i]);
    end
  end

endmodule

// File: rtl/one_counter_v3_iter.sv
// Iterative set/clear-bit counter: consumes CHUNK_W bits per cycle and stops once
// the unconsumed part of the word is zero.
module one_counter_v3_iter
  import one_counter_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CHUNK_W = 4,
  localparam int unsigned CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_clear,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_count
);

  localparam int unsigned PC_W = $clog2(CHUNK_W + 1);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d, shreg_shr;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PC_W-1:0]    chunk_cnt;

  // A full-width shift is spelled out so no out-of-range shift amount is elaborated.
  if (CHUNK_W == DATA_W) begin : g_full_chunk
    assign shreg_shr = '0;
  end else begin : g_part_chunk
    assign shreg_shr = shreg_q >> CHUNK_W;
  end

  popcount_chunk #(
    .W (CHUNK_W)
  ) u_popcount (
    .i_bits (shreg_q[CHUNK_W-1:0]),
    .o_cnt  (chunk_cnt)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    count_d = count_q;
    if (i_clear) begin
      state_d = StIdle;
      shreg_d = '0;
      acc_d   = '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (i_start) begin
            shreg_d = (i_mode == MODE_ZEROS) ? ~i_data : i_data;
            acc_d   = '0;
            state_d = StRun;
          end else begin
            state_d = StIdle;
          end
        end
        StRun: begin
          acc_d   = acc_q + CNT_W'(chunk_cnt);
          shreg_d = shreg_shr;
          if (shreg_shr == '0) begin
            state_d = StDone;
            count_d = acc_d;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      shreg_q <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  assign o_busy  = (state_q == StRun);
  assign o_done  = (state_q == StDone);
  assign o_count = count_q;

endmodule
